// File: rtl/sprite_line_scanner.sv
// -----------------------------------------------------------------------------
// sprite_line_scanner
//
// Per-scanline sprite attribute scanner. A line_start_i pulse starts a walk over
// the sprite attribute RAM (two words per sprite, sprite n at words 2n / 2n+1).
// Each sprite's vertical extent is tested against the latched target line and
// visible sprites are handed to the line renderer over a valid/ready port.
// This block is the only master of the sprite RAM read port.
//
// Parameters
//   NUM_SPRITES  sprites scanned per line (1..128)
//   MAX_HITS     sprites forwarded per line (1..128); later hits are dropped
//
// Ports
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   line_start_i          1-cycle pulse: start (or restart) a scan for line_i
//   line_i                target scanline, sampled with line_start_i
//   sprites_en_i          global enable, sampled with line_start_i
//   ram_rd_en_o/addr_o    sprite RAM read request
//   ram_rd_data_i         sprite RAM read data, valid one cycle after the address
//   hit_valid_o/ready_i   hit record handshake
//   hit_idx_o             sprite index of the hit
//   hit_w0_o, hit_w1_o    raw attribute words of the hit sprite
//   hit_row_o             row inside the sprite = (line - y) mod 1024
//   scan_busy_o           scan in progress (RD0..PUSH)
//   scan_done_o           1-cycle pulse when a scan completes
//   hit_count_o           hits forwarded for the current/last line
//   ovf_o                 only with SPRITE_SCAN_OVF_EN: a hit was dropped because
//                         MAX_HITS was reached; cleared on line_start_i
//
// Build option: define SPRITE_SCAN_OVF_EN to add the ovf_o status port.
// -----------------------------------------------------------------------------
module sprite_line_scanner #(
  parameter int NUM_SPRITES = 128,
  parameter int MAX_HITS    = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        line_start_i,
  input  logic [9:0]  line_i,
  input  logic        sprites_en_i,
  output logic        ram_rd_en_o,
  output logic [7:0]  ram_rd_addr_o,
  input  logic [31:0] ram_rd_data_i,
  output logic        hit_valid_o,
  input  logic        hit_ready_i,
  output logic [6:0]  hit_idx_o,
  output logic [31:0] hit_w0_o,
  output logic [31:0] hit_w1_o,
  output logic [5:0]  hit_row_o,
  output logic        scan_busy_o,
  output logic        scan_done_o,
  output logic [7:0]  hit_count_o
`ifdef SPRITE_SCAN_OVF_EN
  ,
  output logic        ovf_o
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    EVAL = 3'd3,
    PUSH = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  line_q;
  logic [6:0]  idx_q;
  logic [7:0]  count_q;
  logic [31:0] w0_q;

  // Control strobes from the FSM to the datapath.
  logic start, load_hit, accept, advance, skip_full;

  // Y test on word 1 as it arrives from the RAM during EVAL.
  logic [9:0] eval_y;
  logic [9:0] eval_row;
  logic [1:0] eval_z;
  logic [6:0] eval_h;
  logic       eval_hit;
  logic       has_room;
  logic       last_idx;

  assign eval_y   = ram_rd_data_i[9:0];
  assign eval_z   = ram_rd_data_i[19:18];
  assign eval_h   = 7'd8 << ram_rd_data_i[31:30];
  // 10-bit subtraction wraps naturally, so sprites straddling line 1023/0 work.
  assign eval_row = line_q - eval_y;
  assign eval_hit = (eval_z != 2'd0) && (eval_row < 10'(eval_h));
  assign has_room = count_q < 8'(MAX_HITS);
  assign last_idx = idx_q == 7'(NUM_SPRITES - 1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    start         = 1'b0;
    load_hit      = 1'b0;
    accept        = 1'b0;
    advance       = 1'b0;
    skip_full     = 1'b0;
    ram_rd_en_o   = 1'b0;
    ram_rd_addr_o = 8'd0;
    hit_valid_o   = 1'b0;
    scan_busy_o   = 1'b0;
    scan_done_o   = 1'b0;

    case (state_q)
      IDLE: ;
      RD0: begin
        ram_rd_en_o   = 1'b1;
        ram_rd_addr_o = {idx_q, 1'b0};
        scan_busy_o   = 1'b1;
        state_d       = RD1;
      end
      RD1: begin
        ram_rd_en_o   = 1'b1;
        ram_rd_addr_o = {idx_q, 1'b1};
        scan_busy_o   = 1'b1;
        state_d       = EVAL;
      end
      EVAL: begin
        scan_busy_o = 1'b1;
        if (eval_hit && has_room) begin
          load_hit = 1'b1;
          state_d  = PUSH;
        end else begin
          // A visible sprite that cannot be forwarded is counted as overflow.
          skip_full = eval_hit;
          advance   = 1'b1;
          state_d   = last_idx ? DONE : RD0;
        end
      end
      PUSH: begin
        scan_busy_o = 1'b1;
        hit_valid_o = 1'b1;
        if (hit_ready_i) begin
          accept  = 1'b1;
          advance = 1'b1;
          state_d = last_idx ? DONE : RD0;
        end
      end
      DONE: begin
        scan_done_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new line always wins: it aborts any scan in flight (a pending hit is
    // withdrawn without handshake) and also restarts straight out of DONE.
    if (line_start_i) begin
      start     = 1'b1;
      load_hit  = 1'b0;
      accept    = 1'b0;
      advance   = 1'b0;
      skip_full = 1'b0;
      state_d   = sprites_en_i ? RD0 : DONE;
    end
  end

`ifdef SPRITE_SCAN_OVF_EN
  logic ovf_q;
  assign ovf_o = ovf_q;
`endif

  // NOTE: the datapath registers are reset too, because the hit record and
  // count are visible outputs that must read 0 straight out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      line_q    <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      w0_q      <= '0;
      hit_idx_o <= '0;
      hit_w0_o  <= '0;
      hit_w1_o  <= '0;
      hit_row_o <= '0;
`ifdef SPRITE_SCAN_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      if (state_q == RD1) w0_q <= ram_rd_data_i;
      if (start) begin
        line_q  <= line_i;
        idx_q   <= '0;
        count_q <= '0;
`ifdef SPRITE_SCAN_OVF_EN
        ovf_q   <= 1'b0;
`endif
      end else begin
        if (load_hit) begin
          hit_idx_o <= idx_q;
          hit_w0_o  <= w0_q;
          hit_w1_o  <= ram_rd_data_i;
          // row < h <= 64, so the upper bits are always zero for a hit.
          hit_row_o <= eval_row[5:0];
        end
        if (accept) count_q <= count_q + 8'd1;
        if (advance && !last_idx) idx_q <= idx_q + 7'd1;
`ifdef SPRITE_SCAN_OVF_EN
        if (skip_full) ovf_q <= 1'b1;
`endif
      end
    end
  end

  assign hit_count_o = count_q;

endmodule
